// File: rtl/axi_dma_wr_responder.sv
// AXI4 write responder (memory end) for the DMA 64-bit write master, with internal word memory.
// Optional macro WLAST_CHECK_EN: a wlast that disagrees with the beat count turns the burst into SLVERR.
module axi_dma_wr_responder #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000
) (
    input  logic                         axi_aclk,
    input  logic                         axi_areset,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [31:0]                  s_axi_awaddr,
    input  logic [3:0]                   s_axi_awlen,
    input  logic [2:0]                   s_axi_awsize,
    input  logic [1:0]                   s_axi_awburst,
    input  logic [2:0]                   s_axi_awprot,
    input  logic [3:0]                   s_axi_awcache,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    input  logic [63:0]                  s_axi_wdata,
    input  logic [7:0]                   s_axi_wstrb,
    input  logic                         s_axi_wlast,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    output logic [1:0]                   s_axi_bresp,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_rd_addr,
    output logic [63:0]                  dbg_rd_data,
    output logic [31:0]                  burst_count
);
    localparam int         AW          = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [29:0] DEPTH_W    = 30'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t      state;
    logic [3:0]  beat_cnt;
    logic [3:0]  len_q;
    logic        fixed_q;
    logic [29:0] cur_idx;
    logic [1:0]  status;
    logic [63:0] mem [MEM_DEPTH];

    // The borrow of the base subtraction flags addresses below MEM_BASE.
    logic        below_base;
    logic [31:0] offset;
    logic [29:0] start_idx;
    assign {below_base, offset} = {1'b0, s_axi_awaddr} - {1'b0, MEM_BASE};
    assign start_idx = {1'b0, offset[31:3]};

    function automatic logic [1:0] classify(input logic [2:0]  size,
                                            input logic [2:0]  addr_lsb,
                                            input logic [1:0]  burst,
                                            input logic        below,
                                            input logic [29:0] idx);
        if (size != 3'd3 || addr_lsb != 3'd0 || burst[1])
            return RESP_SLVERR;
        if (below || idx >= DEPTH_W)
            return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    logic       w_hs;
    logic       in_range;
    logic       last_beat;
    logic       mem_we;
    logic [1:0] beat_status;

    assign w_hs      = s_axi_wvalid && s_axi_wready;
    assign in_range  = cur_idx < DEPTH_W;
    assign last_beat = beat_cnt == len_q;
    assign mem_we    = w_hs && status == RESP_OKAY && in_range;

    // Status after the current beat; the beat itself is written under the status before it.
    always_comb begin
        beat_status = status;
        if (status == RESP_OKAY && !in_range)
            beat_status = RESP_DECERR;
`ifdef WLAST_CHECK_EN
        if (s_axi_wlast != last_beat)
            beat_status = RESP_SLVERR;
`endif
    end

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_awcache, offset[2:0], s_axi_wlast};

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state         <= IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            burst_count   <= 32'd0;
            beat_cnt      <= 4'd0;
            len_q         <= 4'd0;
            fixed_q       <= 1'b0;
            cur_idx       <= 30'd0;
            status        <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awvalid && s_axi_awready) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        beat_cnt      <= 4'd0;
                        len_q         <= s_axi_awlen;
                        fixed_q       <= s_axi_awburst == 2'b00;
                        cur_idx       <= start_idx;
                        status        <= classify(s_axi_awsize, s_axi_awaddr[2:0], s_axi_awburst,
                                                  below_base, start_idx);
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 4'd1;
                        if (!fixed_q)
                            cur_idx <= cur_idx + 30'd1;
                        status <= beat_status;
                        if (last_beat) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= beat_status;
                            state        <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        burst_count   <= burst_count + 32'd1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory and debug readback carry no reset so contents survive axi_areset.
    always_ff @(posedge axi_aclk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                if (s_axi_wstrb[k])
                    mem[cur_idx[AW-1:0]][8*k +: 8] <= s_axi_wdata[8*k +: 8];
            end
        end
        dbg_rd_data <= mem[dbg_rd_addr];
    end
endmodule
